timer_set_ctrl: RTL and testbench
=================================

# timer_set_ctrl

Control and entry front end for the mm:ss countdown timer. Collects BCD digits from a keypad, presents them as the parallel load word, and drives the load, clear and enable inputs of the mod-10/mod-6 down-counter chain. It generates the one-second enable ticks and watches the chain's all-zero flag to end the run. Every write into the counter chain originates here; the counters only consume.

## Interface
- TICK_DIV, 100: clk cycles per one-second enable tick; must be ≥ 2.
- clk  in  1  system clock; all logic on posedge.
- clear  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_code valid.
- key_code  in  4  digit 0–9; codes 10–15 ignored.
- start  in  1  one-cycle strobe: load-and-run, or resume.
- stop  in  1  one-cycle strobe: pause, cancel entry, or acknowledge done.
- zero_in  in  1  AND of all counter-digit zero flags (time = 00:00).
- data  out  16  load word {min_tens, min_units, sec_tens, sec_units}, BCD.
- loadn  out  1  active-low load strobe to every counter.
- clearn  out  1  active-low clear to every counter.
- en  out  1  enable to the seconds-units counter; one cycle per tick.
- running  out  1  high in RUN.
- done  out  1  high in DONE.

## Operation
- States: CLR, IDLE, LOAD, RUN, PAUSE, DONE.
- CLR: entered while clear is high. clearn=0 and entry buffer=0. Next state is IDLE.
- IDLE: on key_valid with key_code ≤ 9, shift the buffer left one digit and insert the new digit at sec_units. The old min_tens is discarded.
  - stop clears the buffer.
  - start goes to LOAD if the buffer ≠ 0; it is ignored if the buffer = 0.
- Clamping: data always shows the buffer with sec_tens clamped to 5 when the stored digit is > 5. The stored digit is left unclamped.
- LOAD: one cycle with loadn=0; the prescaler resets to 0. Next state is RUN.
- RUN: the prescaler counts 0..TICK_DIV-1 and wraps.
  - en = 1 when prescaler = TICK_DIV-1 and zero_in = 0.
  - zero_in = 1 → DONE.
  - stop → PAUSE.
- PAUSE: the prescaler holds its value and en = 0.
  - start → RUN, resuming from the held prescaler value with no reload.
  - stop → CLR.
- DONE: done = 1 and en = 0. stop or start → CLR.
- key_valid outside IDLE is ignored.
- Simultaneous events, in priority order:
  - clear beats everything.
  - stop beats start.
  - In RUN, zero_in beats stop and beats the tick; no en is issued.
- Reset values (all outputs registered except en): data 0, loadn 1, clearn 0, en 0, running 0, done 0.

## Timing
- start at cycle t in IDLE → loadn=0 at t+1 → running=1 from t+2. The first en is at t+1+TICK_DIV; later en pulses come every TICK_DIV cycles.
- en is combinational from state, prescaler and zero_in, so a counter reaching zero suppresses en in the same cycle.
- The zero_in rise at cycle z in RUN gives done=1 and running=0 at z+1.
- clear deasserted at cycle c → clearn=0 through cycle c, clearn=1 and IDLE from c+1.
- Key to data latency is 1 cycle.
- Prescaler width is $clog2(TICK_DIV). It wraps at TICK_DIV-1 and never exceeds it.

## Structure
- Shared package timer_pkg holds:
  - the state enum (CLR, IDLE, LOAD, RUN, PAUSE, DONE);
  - the BCD digit width (4);
  - the digit count (4);
  - the sec_tens maximum constant (5).
- Sub-module tick_gen holds the prescaler. Inputs: clk, clear, run, restart. Output: tick. It is reused by other timer blocks.
- The FSM and entry shift register live in the top module.

## Test plan
- Keys 1,2,3,4 then start, with TICK_DIV=4 → data=16'h1234, loadn low for exactly 1 cycle, en pulses every 4 cycles starting 5 cycles after start.
- Keys 9,9,9 → data=16'h0959 (sec_tens clamped); key_code 12 leaves data unchanged.
- RUN, stop, wait 10 cycles, start → no en during PAUSE; the next en arrives after the remaining prescaler count, not after a full TICK_DIV.
- zero_in=1 and stop in the same RUN cycle → DONE, done=1, no en; a later stop → clearn low 1 cycle, then IDLE with data=0.
- start with an empty buffer → stays IDLE, loadn stays 1, running stays 0.
- clear asserted mid-RUN → next cycle: en=0, running=0, clearn=0, data=0; IDLE one cycle after release.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the mm:ss countdown timer blocks.
package timer_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned DIGIT_N      = 4;
  localparam int unsigned WORD_W       = DIGIT_W * DIGIT_N;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } state_t;

  // Present the entry buffer with sec_tens limited to a valid seconds digit.
  function automatic logic [WORD_W-1:0] clamp_word(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0]  r;
    logic [DIGIT_W-1:0] st;
    r  = w;
    st = w[2*DIGIT_W-1:DIGIT_W];
    if (st > SEC_TENS_MAX) st = SEC_TENS_MAX;
    r[2*DIGIT_W-1:DIGIT_W] = st;
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while run is high, holds otherwise.
module tick_gen #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Prescaler: cleared on reset or restart, wraps at LAST while running.
  always_ff @(posedge clk) begin
    if (clear || restart) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/timer_set_ctrl.sv
// Keypad entry, load/clear/enable sequencing for the mm:ss down-counter chain.
module timer_set_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic              start,
  input  logic              stop,
  input  logic              zero_in,
  output logic [WORD_W-1:0] data,
  output logic              loadn,
  output logic              clearn,
  output logic              en,
  output logic              running,
  output logic              done
);

  state_t            r_state;
  state_t            w_next;
  logic [WORD_W-1:0] r_buf;
  logic [WORD_W-1:0] w_buf_next;
  logic              r_loadn;
  logic              r_clearn;
  logic              r_running;
  logic              r_done;
  logic              w_tick;
  logic              w_run;
  logic              w_restart;

  assign w_run     = (r_state == RUN);
  assign w_restart = (r_state == LOAD);

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .clear  (clear),
    .run    (w_run),
    .restart(w_restart),
    .tick   (w_tick)
  );

  // Next-state and entry-buffer update; stop has priority over start and keys.
  always_comb begin
    w_next     = r_state;
    w_buf_next = r_buf;
    case (r_state)
      CLR:  w_next = IDLE;
      IDLE: begin
        if (stop) begin
          w_buf_next = '0;
        end else begin
          if (key_valid && (key_code <= 4'd9)) begin
            w_buf_next = {r_buf[WORD_W-DIGIT_W-1:0], key_code};
          end
          if (start && (r_buf != '0)) w_next = LOAD;
        end
      end
      LOAD: w_next = RUN;
      RUN: begin
        if (zero_in)   w_next = DONE;
        else if (stop) w_next = PAUSE;
      end
      PAUSE: begin
        if (stop)       w_next = CLR;
        else if (start) w_next = RUN;
      end
      DONE: begin
        if (stop || start) w_next = CLR;
      end
      default: w_next = CLR;
    endcase
    // The buffer is empty whenever the chain is being cleared.
    if (w_next == CLR) w_buf_next = '0;
  end

  // State, buffer and registered status outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state   <= CLR;
      r_buf     <= '0;
      r_loadn   <= 1'b1;
      r_clearn  <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_buf     <= w_buf_next;
      r_loadn   <= (w_next != LOAD);
      r_clearn  <= (w_next != CLR);
      r_running <= (w_next == RUN);
      r_done    <= (w_next == DONE);
    end
  end

  assign data    = clamp_word(r_buf);
  assign loadn   = r_loadn;
  assign clearn  = r_clearn;
  assign running = r_running;
  assign done    = r_done;
  assign en      = (r_state == RUN) && w_tick && !zero_in;

endmodule

// File: tb/tb_timer_set_ctrl.sv
// Randomized and directed bench for timer_set_ctrl against a seconds-level reference model.
module tb_timer_set_ctrl;

  localparam int unsigned TD = 4;

  localparam int P_CLR   = 0;
  localparam int P_IDLE  = 1;
  localparam int P_LOAD  = 2;
  localparam int P_RUN   = 3;
  localparam int P_PAUSE = 4;
  localparam int P_DONE  = 5;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        zero_in = 1'b0;
  logic [15:0] data;
  logic        loadn, clearn, en, running, done;

  always #5 clk = ~clk;

  timer_set_ctrl #(
    .TICK_DIV(TD)
  ) dut (
    .clk      (clk),
    .clear    (clear),
    .key_valid(key_valid),
    .key_code (key_code),
    .start    (start),
    .stop     (stop),
    .zero_in  (zero_in),
    .data     (data),
    .loadn    (loadn),
    .clearn   (clearn),
    .en       (en),
    .running  (running),
    .done     (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // staged stimulus, applied at the next falling edge
  logic s_clear = 1'b0, s_kv = 1'b0, s_start = 1'b0, s_stop = 1'b0;
  int   s_kc = 0;

  // reference model: phase, digits (0 = sec units .. 3 = min tens), prescaler, chain time in seconds
  int ph    = P_CLR;
  int dig[4] = '{0, 0, 0, 0};
  int presc = 0;
  int tsec  = 0;
  logic e_en;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int shown_sec_tens();
    return (dig[1] > 5) ? 5 : dig[1];
  endfunction

  function automatic logic [15:0] exp_data();
    return {4'(dig[3]), 4'(dig[2]), 4'(shown_sec_tens()), 4'(dig[0])};
  endfunction

  task automatic cycle();
    logic zi;
    int   nph;
    bit   nz;
    @(negedge clk);
    clear     = s_clear;
    key_valid = s_kv;
    key_code  = 4'(s_kc);
    start     = s_start;
    stop      = s_stop;
    zi        = (tsec == 0);
    zero_in   = zi;
    e_en      = (ph == P_RUN) && (presc == TD - 1) && !zi;
    #1;
    chk("data",    32'(data),    32'(exp_data()));
    chk("loadn",   32'(loadn),   32'(ph != P_LOAD));
    chk("clearn",  32'(clearn),  32'(ph != P_CLR));
    chk("running", 32'(running), 32'(ph == P_RUN));
    chk("done",    32'(done),    32'(ph == P_DONE));
    chk("en",      32'(en),      32'(e_en));
    @(posedge clk);
    // counter chain environment, driven by the model's own outputs
    if (ph == P_CLR)       tsec = 0;
    else if (ph == P_LOAD) tsec = (dig[3] * 10 + dig[2]) * 60 + shown_sec_tens() * 10 + dig[0];
    else if (e_en)         tsec = tsec - 1;
    // prescaler
    if (s_clear || ph == P_LOAD) presc = 0;
    else if (ph == P_RUN)        presc = (presc + 1) % TD;
    // control
    nz  = (dig[0] != 0) || (dig[1] != 0) || (dig[2] != 0) || (dig[3] != 0);
    nph = ph;
    if (s_clear) nph = P_CLR;
    else begin
      case (ph)
        P_CLR:  nph = P_IDLE;
        P_IDLE: begin
          if (s_stop) dig = '{0, 0, 0, 0};
          else begin
            if (s_kv && s_kc <= 9) begin
              dig[3] = dig[2]; dig[2] = dig[1]; dig[1] = dig[0]; dig[0] = s_kc;
            end
            if (s_start && nz) nph = P_LOAD;
          end
        end
        P_LOAD:  nph = P_RUN;
        P_RUN:   if (zi) nph = P_DONE; else if (s_stop) nph = P_PAUSE;
        P_PAUSE: if (s_stop) nph = P_CLR; else if (s_start) nph = P_RUN;
        P_DONE:  if (s_stop || s_start) nph = P_CLR;
        default: nph = P_CLR;
      endcase
    end
    if (nph == P_CLR) dig = '{0, 0, 0, 0};
    ph = nph;
    s_clear = 1'b0; s_kv = 1'b0; s_start = 1'b0; s_stop = 1'b0;
    #1;
  endtask

  task automatic key(input int k);
    s_kv = 1'b1; s_kc = k; cycle();
  endtask

  task automatic press_start();
    s_start = 1'b1; cycle();
  endtask

  task automatic press_stop();
    s_stop = 1'b1; cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int timeout;
    int r;
    repeat (2) @(posedge clk);

    // reset state
    s_clear = 1'b1; cycle();
    chk("rst_clearn", 32'(clearn), 32'd0);
    cycle();
    chk("idle_clearn", 32'(clearn), 32'd1);

    // entry 12:34, start, pause/resume, cancel
    key(1); key(2); key(3); key(4);
    chk("data_1234", 32'(data), 32'h1234);
    press_start();
    chk("load_low", 32'(loadn), 32'd0);
    idle(1);
    chk("load_one", 32'(loadn), 32'd1);
    idle(17);
    press_stop();
    idle(10);
    press_start();
    idle(12);
    press_stop();
    press_stop();
    idle(1);
    chk("cancel_data", 32'(data), 32'd0);

    // clamp and invalid key
    key(9); key(9); key(9);
    chk("data_0959", 32'(data), 32'h0959);
    key(12);
    chk("key12_ign", 32'(data), 32'h0959);
    press_stop();
    chk("stop_clr", 32'(data), 32'd0);

    // start with empty buffer
    press_start();
    chk("empty_loadn", 32'(loadn), 32'd1);
    idle(1);
    chk("empty_run", 32'(running), 32'd0);

    // run 00:02 to zero, with stop in the same cycle as zero_in
    key(2);
    press_start();
    timeout = 1;
    for (int i = 0; i < 100; i++) begin
      if (ph == P_RUN && tsec == 0) begin
        timeout = 0;
        break;
      end
      cycle();
    end
    chk("zero_reached", 32'(timeout), 32'd0);
    press_stop();
    chk("done_hi", 32'(done), 32'd1);
    chk("done_en", 32'(en), 32'd0);
    press_stop();
    chk("done_clr", 32'(clearn), 32'd0);
    idle(1);
    chk("after_clr", 32'(clearn), 32'd1);

    // clear in the middle of a run
    key(5);
    press_start();
    idle(7);
    s_clear = 1'b1; cycle();
    chk("clr_run", 32'(running), 32'd0);
    chk("clr_data", 32'(data), 32'd0);
    idle(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 1) s_clear = 1'b1;
      else if (r < 15) begin
        s_kv = 1'b1;
        s_kc = int'($urandom_range(0, 15));
      end
      else if (r < 20) s_start = 1'b1;
      else if (r < 25) s_stop = 1'b1;
      else if (r < 27) begin
        s_start = 1'b1;
        s_stop  = 1'b1;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
